my_ram8: RTL
============

Name: my_ram8

Overview:
- 8-entry x 16-bit register file that consumes the existing 8-way primitives.
- Load decode uses my_dmux8way; read select uses my_mux8way16; all-zero status uses my_or8way-style reduction.
- Adds a sequential bulk-clear sequencer with a busy flag. It sits downstream of the gates8way library as the first storage block, and the later RAM64 is built from it.

Parameters:
- WIDTH, 16, data word width in bits; must match my_mux8way16 (16).
- CLR_VALUE, 16'h0000, value written to each entry during bulk clear.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- in  input  WIDTH  write data
- load  input  1  write strobe for entry address
- address  input  3  read/write entry select
- clear  input  1  single-cycle request to start bulk clear
- out  output  WIDTH  read data of entry address
- busy  output  1  high while the clear sequence is running
- all_zero  output  1  high when every entry equals 0

Behaviour:
- Reset (async, rst=1):
  - all 8 entries = 0; FSM = IDLE; clear counter = 0; busy = 0.
  - out = 0 and all_zero = 1 while rst is held.
- Read: combinational, out = entry[address]. A write becomes visible on out from the cycle after the load edge. No read latency beyond that.
- Write: at a rising edge with load=1, busy=0 and clear=0, entry[address] <= in. Only the addressed entry changes; the decode goes through my_dmux8way.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on a rising edge with clear=1. The counter is loaded to 0 and busy goes to 1 the next cycle.
  - In CLEAR, each edge writes entry[counter] <= CLR_VALUE and increments the counter. The counter covers 0..7, so there are 8 write cycles.
  - CLEAR -> IDLE on the edge that writes entry 7. busy drops the cycle after. Total busy time: exactly 8 cycles.
- Simultaneous events:
  - clear=1 and load=1 in IDLE: clear wins; the load is dropped.
  - load during CLEAR: ignored, no write. Upstream must watch busy.
  - clear during CLEAR: ignored; no restart and no extension.
- Counter wrap: the 3-bit counter wraps from 7 to 0 on the final edge, so it is 0 again in IDLE.
- Reset mid-clear: asynchronous abort. All entries go to 0 immediately and the FSM returns to IDLE, with no partial state left.
- all_zero: combinational NOR over all 128 stored bits; reflects register contents, not in.
- Read during CLEAR: out shows current contents, so already-cleared entries read CLR_VALUE.

Optional Feature:
- Macro: MY_RAM8_BYPASS_EN.
- Defined: when load=1, busy=0 and clear=0, out = in combinationally (write-first read-through), regardless of address matching. This gives same-cycle forwarding for the downstream ALU path.
- Undefined: out always reflects stored contents; no in-to-out combinational path.
- Storage, FSM and all_zero are identical in both builds.

Decomposition:
- Package my_ram8_pkg holds:
  - localparam DEPTH=8 and ADDR_W=3;
  - typedef enum logic {IDLE, CLEAR} ram8_state_t;
  - typedef logic [2:0] ram8_addr_t.
- One natural sub-module, my_register16: a WIDTH-bit register with load enable and async active-high reset, instantiated 8 times.
- Existing my_dmux8way and my_mux8way16 are reused unchanged for decode and select.

Test Plan:
- Reset then idle: rst pulse, no stimulus -> out=0x0000 for all 8 addresses, all_zero=1, busy=0.
- Write/read: load=1 at addr 3 with in=0xBEEF, then addr 5 with 0x1234 -> next cycle addr3 reads 0xBEEF, addr5 reads 0x1234, other addresses 0x0000, all_zero=0.
- Bulk clear: fill all entries with 0xFFFF, pulse clear for 1 cycle -> busy=1 for exactly 8 cycles; entry k reads 0x0000 from k+1 cycles after busy rises; all_zero=1 after busy falls.
- Contention: during CLEAR drive load=1 at addr 7 with 0xAAAA and re-pulse clear -> no write, busy still 8 cycles total, addr7=0x0000. In IDLE, clear=1 together with load=1 (0x5555 at addr 2) -> addr2 stays 0x0000 after the sequence.
- Reset mid-clear: assert rst asynchronously 3 cycles into CLEAR (between edges) -> all entries 0, busy=0 immediately. A subsequent load of 0x0F0F at addr 1 succeeds on the next edge.
- Bypass build (MY_RAM8_BYPASS_EN): load=1 with in=0xCAFE at addr 4 -> out=0xCAFE in the same cycle. Without the macro, out shows the old value (0x0000) that cycle and 0xCAFE the next.

Source files
------------

// File: rtl/my_ram8_pkg.sv
// Shared types and sizes for the 8-entry register file (my_ram8) and its helpers.
package my_ram8_pkg;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    typedef enum logic {IDLE, CLEAR} ram8_state_t;
    typedef logic [ADDR_W-1:0] ram8_addr_t;
endpackage

// File: rtl/my_dmux8way.sv
// 1-to-8 demultiplexer: routes in to the output selected by sel, others 0.
module my_dmux8way (
    input  logic       in,
    input  logic [2:0] sel,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h
);
    assign a = in & (sel == 3'd0);
    assign b = in & (sel == 3'd1);
    assign c = in & (sel == 3'd2);
    assign d = in & (sel == 3'd3);
    assign e = in & (sel == 3'd4);
    assign f = in & (sel == 3'd5);
    assign g = in & (sel == 3'd6);
    assign h = in & (sel == 3'd7);
endmodule

// File: rtl/my_mux8way16.sv
// 8-to-1 multiplexer of 16-bit words.
module my_mux8way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    output logic [15:0] out
);
    always_comb begin
        out = a;
        case (sel)
            3'd0: out = a;
            3'd1: out = b;
            3'd2: out = c;
            3'd3: out = d;
            3'd4: out = e;
            3'd5: out = f;
            3'd6: out = g;
            3'd7: out = h;
            default: out = a;
        endcase
    end
endmodule

// File: rtl/my_register16.sv
// WIDTH-bit register with load enable and asynchronous active-high reset to 0.
module my_register16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic [WIDTH-1:0] out
);
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_reg <= '0;
        else if (load)
            data_reg <= in;
    end

    assign out = data_reg;
endmodule

// File: rtl/my_ram8.sv
// 8 x WIDTH register file with a sequential bulk-clear sequencer and busy flag.
// Optional write-first read-through enabled by defining MY_RAM8_BYPASS_EN.
module my_ram8
    import my_ram8_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       address,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             all_zero
);
    ram8_state_t state_reg, state_next;
    ram8_addr_t  cnt_reg, cnt_next;

    logic             wr_en;
    ram8_addr_t       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [DEPTH-1:0] entry_load;
    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [DEPTH-1:0] entry_nz;
    logic [WIDTH-1:0] rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // One shared write port: user writes in IDLE, the sequencer owns it in CLEAR.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wr_en      = 1'b0;
        wr_addr    = address;
        wr_data    = in;
        case (state_reg)
            IDLE: begin
                if (clear) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end else if (load) begin
                    wr_en = 1'b1;
                end
            end
            CLEAR: begin
                wr_en    = 1'b1;
                wr_addr  = cnt_reg;
                wr_data  = CLR_VALUE;
                cnt_next = ram8_addr_t'(cnt_reg + 3'd1);
                if (cnt_reg == ram8_addr_t'(DEPTH - 1))
                    state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg == CLEAR);

    my_dmux8way u_dmux (
        .in  (wr_en),
        .sel (wr_addr),
        .a   (entry_load[0]),
        .b   (entry_load[1]),
        .c   (entry_load[2]),
        .d   (entry_load[3]),
        .e   (entry_load[4]),
        .f   (entry_load[5]),
        .g   (entry_load[6]),
        .h   (entry_load[7])
    );

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            my_register16 #(.WIDTH(WIDTH)) u_reg (
                .clk  (clk),
                .rst  (rst),
                .in   (wr_data),
                .load (entry_load[gi]),
                .out  (entry_q[gi])
            );
            assign entry_nz[gi] = |entry_q[gi];
        end
    endgenerate

    assign all_zero = ~|entry_nz;

    my_mux8way16 u_mux (
        .a   (entry_q[0]),
        .b   (entry_q[1]),
        .c   (entry_q[2]),
        .d   (entry_q[3]),
        .e   (entry_q[4]),
        .f   (entry_q[5]),
        .g   (entry_q[6]),
        .h   (entry_q[7]),
        .sel (address),
        .out (rd_data)
    );

`ifdef MY_RAM8_BYPASS_EN
    // Forward only when the write would actually be accepted this edge.
    assign out = (load && !busy && !clear && !rst) ? in : rd_data;
`else
    assign out = rd_data;
`endif
endmodule
